// File: rtl/dcache_wt_pkg.sv
// Shared CPU types (word_t, ramstate_t) and the data cache state/frame types.
package cpu_types_pkg;
  typedef logic [31:0] word_t;
  typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
endpackage

package dcache_wt_pkg;
  import cpu_types_pkg::*;

  // Tag field sized for the smallest legal cache (2 frames); larger caches zero-extend.
  localparam int TAG_MAXW = 29;

  typedef enum logic [2:0] {IDLE, RDMISS, WRITE, FLUSH, HALTED} dcache_state_t;

  typedef struct packed {
    logic                valid;
    logic [TAG_MAXW-1:0] tag;
    word_t               data;
  } dcache_frame_t;

  function automatic logic [TAG_MAXW-1:0] addr_tag(input word_t addr, input int idxw);
    return TAG_MAXW'(addr >> (idxw + 2));
  endfunction
endpackage

// File: rtl/dcache_wt_if.sv
// Datapath-side and RAM-side signal bundle of the write-through data cache.
interface dcache_wt_if;
  import cpu_types_pkg::*;

  logic      dREN;
  logic      dWEN;
  word_t     daddr;
  word_t     dstore;
  logic      halt;
  logic      dhit;
  word_t     dload;
  logic      flushed;
  logic      ramREN;
  logic      ramWEN;
  word_t     ramaddr;
  word_t     ramstore;
  word_t     ramload;
  ramstate_t ramstate;

  modport slave (
    input  dREN, dWEN, daddr, dstore, halt, ramload, ramstate,
    output dhit, dload, flushed, ramREN, ramWEN, ramaddr, ramstore
  );

  modport master (
    output dREN, dWEN, daddr, dstore, halt, ramload, ramstate,
    input  dhit, dload, flushed, ramREN, ramWEN, ramaddr, ramstore
  );
endinterface

// File: rtl/dcache_frames.sv
// Direct-mapped frame store: combinational read, one synchronous write per cycle.
module dcache_frames
  import cpu_types_pkg::*;
  import dcache_wt_pkg::*;
#(
  parameter int NSETS = 16,
  localparam int IDXW = $clog2(NSETS)
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [IDXW-1:0]     rd_idx,
  output dcache_frame_t       rd_frame,
  input  logic [IDXW-1:0]     wr_idx,
  input  logic                fill_en,
  input  logic [TAG_MAXW-1:0] fill_tag,
  input  word_t               fill_data,
  input  logic                upd_en,
  input  word_t               upd_data,
  input  logic                inv_en
);

  dcache_frame_t frame_mem [NSETS];

  assign rd_frame = frame_mem[rd_idx];

  // The controller never asserts more than one write enable at a time.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < NSETS; i++) begin
        frame_mem[i] <= '0;
      end
    end else if (fill_en) begin
      frame_mem[wr_idx] <= '{valid: 1'b1, tag: fill_tag, data: fill_data};
    end else if (upd_en) begin
      frame_mem[wr_idx].data <= upd_data;
    end else if (inv_en) begin
      frame_mem[wr_idx].valid <= 1'b0;
    end
  end

endmodule

// File: rtl/dcache_wt.sv
// Direct-mapped write-through, no-write-allocate data cache with halt flush.
// Optional hit/miss counters are enabled with `define DCACHE_STATS_EN.
module dcache_wt
  import cpu_types_pkg::*;
  import dcache_wt_pkg::*;
#(
  parameter int NSETS = 16
) (
  input  logic      CLK,
  input  logic      RST,
  dcache_wt_if.slave bus
`ifdef DCACHE_STATS_EN
  ,
  output word_t     hit_count,
  output word_t     miss_count
`endif
);

  localparam int IDXW = $clog2(NSETS);

  dcache_state_t       state, next_state;
  logic [IDXW-1:0]     flush_cnt;
  logic [IDXW-1:0]     idx;
  logic [IDXW-1:0]     wr_idx;
  logic [TAG_MAXW-1:0] tag;
  dcache_frame_t       frame;
  word_t               word_addr;
  logic                tag_hit;
  logic                fill_en, upd_en, inv_en;

  assign idx       = bus.daddr[IDXW+1:2];
  assign tag       = addr_tag(bus.daddr, IDXW);
  assign word_addr = {bus.daddr[31:2], 2'b00};
  assign tag_hit   = frame.valid && (frame.tag == tag);
  assign wr_idx    = (state == FLUSH) ? flush_cnt : idx;

  dcache_frames #(.NSETS(NSETS)) frames_u (
    .CLK       (CLK),
    .RST       (RST),
    .rd_idx    (idx),
    .rd_frame  (frame),
    .wr_idx    (wr_idx),
    .fill_en   (fill_en),
    .fill_tag  (tag),
    .fill_data (bus.ramload),
    .upd_en    (upd_en),
    .upd_data  (bus.dstore),
    .inv_en    (inv_en)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      flush_cnt <= '0;
    end else begin
      state <= next_state;
      if (state == FLUSH) begin
        flush_cnt <= flush_cnt + 1'b1;
      end
    end
  end

  // RAM request lines follow the held request level so an abort drops them at once.
  always_comb begin
    next_state   = state;
    bus.dhit     = 1'b0;
    bus.dload    = '0;
    bus.flushed  = 1'b0;
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = '0;
    bus.ramstore = '0;
    fill_en      = 1'b0;
    upd_en       = 1'b0;
    inv_en       = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.halt) begin
          next_state = FLUSH;
        end else if (bus.dWEN) begin
          next_state = WRITE;
        end else if (bus.dREN) begin
          if (tag_hit) begin
            bus.dhit  = 1'b1;
            bus.dload = frame.data;
          end else begin
            next_state = RDMISS;
          end
        end
      end
      RDMISS: begin
        if (!bus.dREN) begin
          next_state = IDLE;
        end else begin
          bus.ramREN  = 1'b1;
          bus.ramaddr = word_addr;
          if (bus.ramstate == ACCESS) begin
            bus.dhit   = 1'b1;
            bus.dload  = bus.ramload;
            fill_en    = 1'b1;
            next_state = IDLE;
          end
        end
      end
      WRITE: begin
        if (!bus.dWEN) begin
          next_state = IDLE;
        end else begin
          bus.ramWEN   = 1'b1;
          bus.ramaddr  = word_addr;
          bus.ramstore = bus.dstore;
          if (bus.ramstate == ACCESS) begin
            bus.dhit   = 1'b1;
            upd_en     = tag_hit;
            next_state = IDLE;
          end
        end
      end
      FLUSH: begin
        inv_en = 1'b1;
        if (flush_cnt == IDXW'(NSETS - 1)) begin
          next_state = HALTED;
        end
      end
      HALTED: begin
        bus.flushed = 1'b1;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

`ifdef DCACHE_STATS_EN
  logic read_hit, miss_start;

  assign read_hit   = (state == IDLE) && !bus.halt && !bus.dWEN && bus.dREN && tag_hit;
  assign miss_start = (state == IDLE) && (next_state == RDMISS);

  always_ff @(posedge CLK) begin
    if (RST) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (read_hit && (hit_count != 32'hFFFF_FFFF)) begin
        hit_count <= hit_count + 32'd1;
      end
      if (miss_start && (miss_count != 32'hFFFF_FFFF)) begin
        miss_count <= miss_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dcache_wt.sv
// Randomized self-checking bench for dcache_wt against a word-address cache model.
module tb_dcache_wt;
  import cpu_types_pkg::*;

  localparam int NSETS = 16;
  localparam int IDXW  = $clog2(NSETS);

  logic CLK = 1'b0;
  logic RST = 1'b1;

  dcache_wt_if bus();

`ifdef DCACHE_STATS_EN
  word_t hit_count, miss_count;
  word_t m_hits, m_misses;
`endif

  dcache_wt #(.NSETS(NSETS)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
`ifdef DCACHE_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  always #5 CLK = ~CLK;

  // Model: each frame remembers the full word address it caches.
  bit          m_valid [NSETS];
  logic [29:0] m_waddr [NSETS];
  word_t       m_data  [NSETS];

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  logic  e_hit, e_load_ok, e_ren, e_wen, e_fl, e_quiet;
  word_t e_load, e_addr, e_store;

  function automatic int slot(input word_t a);
    return int'(a[IDXW+1:2]);
  endfunction

  function automatic bit model_hit(input word_t a);
    return m_valid[slot(a)] && (m_waddr[slot(a)] == a[31:2]);
  endfunction

  function automatic void model_clear();
    foreach (m_valid[i]) m_valid[i] = 1'b0;
  endfunction

  function automatic ramstate_t hold_state(input bit rnd);
    if (!rnd) return BUSY;
    case ($urandom_range(0, 2))
      0:       return FREE;
      1:       return ERROR;
      default: return BUSY;
    endcase
  endfunction

  task automatic checkOutput(input string name, input word_t act, input word_t exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic applyStimulus(input logic ren, input logic wen, input word_t addr,
                               input word_t store, input logic hlt, input ramstate_t rs,
                               input word_t rl);
    bus.dREN     = ren;
    bus.dWEN     = wen;
    bus.daddr    = addr;
    bus.dstore   = store;
    bus.halt     = hlt;
    bus.ramstate = rs;
    bus.ramload  = rl;
  endtask

  task automatic expect_out(input logic hit, input word_t load, input logic load_ok,
                            input logic ren, input logic wen, input word_t addr,
                            input word_t store, input logic fl, input logic quiet);
    e_hit     = hit;
    e_load    = load;
    e_load_ok = load_ok;
    e_ren     = ren;
    e_wen     = wen;
    e_addr    = addr;
    e_store   = store;
    e_fl      = fl;
    e_quiet   = quiet;
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  always @(negedge CLK) begin
    if (chk_en) begin
      checkOutput("dhit", {31'b0, bus.dhit}, {31'b0, e_hit});
      checkOutput("ramREN", {31'b0, bus.ramREN}, {31'b0, e_ren});
      checkOutput("ramWEN", {31'b0, bus.ramWEN}, {31'b0, e_wen});
      checkOutput("flushed", {31'b0, bus.flushed}, {31'b0, e_fl});
      if (e_hit && e_load_ok) checkOutput("dload", bus.dload, e_load);
      if (e_ren || e_wen) checkOutput("ramaddr", bus.ramaddr, e_addr);
      if (e_wen) checkOutput("ramstore", bus.ramstore, e_store);
      if (e_quiet) begin
        checkOutput("idle_dload", bus.dload, 32'h0);
        checkOutput("idle_ramaddr", bus.ramaddr, 32'h0);
        checkOutput("idle_ramstore", bus.ramstore, 32'h0);
      end
`ifdef DCACHE_STATS_EN
      checkOutput("hit_count", hit_count, m_hits);
      checkOutput("miss_count", miss_count, m_misses);
`endif
    end
  end

  task automatic idle(input logic fl);
    applyStimulus(1'b0, 1'b0, $urandom, 32'h0, 1'b0, FREE, $urandom);
    expect_out(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, fl, 1'b1);
    next_cycle();
  endtask

  task automatic do_read(input word_t addr, input int nbusy, input word_t rdata,
                         input bit abort, input bit rnd_hold);
    word_t wa;
    int s;
    wa = {addr[31:2], 2'b00};
    s  = slot(addr);
    if (model_hit(addr)) begin
      applyStimulus(1'b1, 1'b0, addr, $urandom, 1'b0, hold_state(1'b1), $urandom);
      expect_out(1'b1, m_data[s], 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      next_cycle();
`ifdef DCACHE_STATS_EN
      m_hits++;
`endif
    end else begin
      applyStimulus(1'b1, 1'b0, addr, 32'h0, 1'b0, FREE, 32'h0);
      expect_out(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      next_cycle();
`ifdef DCACHE_STATS_EN
      m_misses++;
`endif
      for (int k = 0; k < nbusy; k++) begin
        applyStimulus(1'b1, 1'b0, addr, 32'h0, 1'b0, hold_state(rnd_hold), $urandom);
        expect_out(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, wa, 32'h0, 1'b0, 1'b0);
        next_cycle();
      end
      if (abort) begin
        applyStimulus(1'b0, 1'b0, addr, 32'h0, 1'b0, ACCESS, rdata);
        expect_out(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        next_cycle();
      end else begin
        applyStimulus(1'b1, 1'b0, addr, 32'h0, 1'b0, ACCESS, rdata);
        expect_out(1'b1, rdata, 1'b1, 1'b1, 1'b0, wa, 32'h0, 1'b0, 1'b0);
        next_cycle();
        m_valid[s] = 1'b1;
        m_waddr[s] = addr[31:2];
        m_data[s]  = rdata;
      end
    end
    idle(1'b0);
  endtask

  task automatic do_write(input word_t addr, input word_t data, input int nbusy, input bit abort);
    word_t wa;
    logic both;
    wa   = {addr[31:2], 2'b00};
    both = 1'($urandom_range(0, 1));
    applyStimulus(both, 1'b1, addr, data, 1'b0, FREE, 32'h0);
    expect_out(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    next_cycle();
    for (int k = 0; k < nbusy; k++) begin
      applyStimulus(both, 1'b1, addr, data, 1'b0, hold_state(1'b1), $urandom);
      expect_out(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, wa, data, 1'b0, 1'b0);
      next_cycle();
    end
    if (abort) begin
      applyStimulus(1'b0, 1'b0, addr, data, 1'b0, ACCESS, $urandom);
      expect_out(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      next_cycle();
    end else begin
      applyStimulus(both, 1'b1, addr, data, 1'b0, ACCESS, $urandom);
      expect_out(1'b1, 32'h0, 1'b0, 1'b0, 1'b1, wa, data, 1'b0, 1'b0);
      next_cycle();
      if (model_hit(addr)) m_data[slot(addr)] = data;
    end
    idle(1'b0);
  endtask

  task automatic do_reset(input logic fl);
    RST = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, FREE, 32'h0);
    expect_out(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, fl, 1'b1);
    next_cycle();
    RST = 1'b0;
    model_clear();
`ifdef DCACHE_STATS_EN
    m_hits   = 32'h0;
    m_misses = 32'h0;
`endif
  endtask

  task automatic do_halt();
    applyStimulus(1'b0, 1'b0, $urandom, 32'h0, 1'b1, FREE, 32'h0);
    expect_out(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    next_cycle();
    model_clear();
    for (int k = 0; k < NSETS + 3; k++) begin
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom,
                    1'($urandom_range(0, 1)), ACCESS, $urandom);
      expect_out(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, (k >= NSETS), 1'b0);
      next_cycle();
    end
  endtask

  initial begin
    word_t a;
    int op;
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, FREE, 32'h0);
    model_clear();
`ifdef DCACHE_STATS_EN
    m_hits   = 32'h0;
    m_misses = 32'h0;
`endif
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    chk_en = 1'b1;
    idle(1'b0);

    // Cold read, repeat hit, conflict eviction.
    do_read(32'h40, 2, 32'hDEADBEEF, 1'b0, 1'b0);
    checkOutput("pin_fill_0x40", m_data[0], 32'hDEADBEEF);
    checkOutput("pin_cached_0x40", {31'b0, model_hit(32'h40)}, 32'h1);
    do_read(32'h40, 0, 32'h0, 1'b0, 1'b0);
    do_read(32'h80, 1, 32'hCAFEF00D, 1'b0, 1'b0);
    checkOutput("pin_evicted_0x40", {31'b0, model_hit(32'h40)}, 32'h0);
    do_read(32'h40, 2, 32'h0BADF00D, 1'b0, 1'b0);

    // Write hit updates the frame; write miss does not allocate.
    do_write(32'h40, 32'h12345678, 2, 1'b0);
    checkOutput("pin_update_0x40", m_data[0], 32'h12345678);
    do_read(32'h40, 0, 32'h0, 1'b0, 1'b0);
    do_write(32'hC4, 32'hAAAA5555, 1, 1'b0);
    checkOutput("pin_noalloc_0xC4", {31'b0, model_hit(32'hC4)}, 32'h0);
    do_read(32'hC4, 1, 32'h0F0F0F0F, 1'b0, 1'b0);

    // Aborted miss leaves the frame unfilled.
    do_read(32'h100, 2, 32'h11111111, 1'b1, 1'b0);
    checkOutput("pin_abort_0x100", {31'b0, model_hit(32'h100)}, 32'h0);
    do_read(32'h100, 1, 32'h22222222, 1'b0, 1'b0);

    for (int n = 0; n < 300; n++) begin
      a = (word_t'($urandom_range(0, 3)) << (IDXW + 2)) |
          (word_t'($urandom_range(0, NSETS - 1)) << 2) | word_t'($urandom_range(0, 3));
      op = $urandom_range(0, 9);
      if (op < 5)       do_read(a, $urandom_range(0, 3), $urandom, 1'b0, 1'b1);
      else if (op < 8)  do_write(a, $urandom, $urandom_range(0, 3), 1'b0);
      else if (op == 8) do_read(a, $urandom_range(0, 3), $urandom, 1'b1, 1'b1);
      else              do_write(a, $urandom, $urandom_range(0, 3), 1'b1);
    end

    // Reset in the middle of a read miss.
    do_read(32'h40, 1, 32'h55AA55AA, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'h204, 32'h0, 1'b0, FREE, 32'h0);
    expect_out(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    next_cycle();
    applyStimulus(1'b1, 1'b0, 32'h204, 32'h0, 1'b0, BUSY, 32'h0);
    expect_out(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h204, 32'h0, 1'b0, 1'b0);
    next_cycle();
    RST = 1'b1;
    expect_out(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h204, 32'h0, 1'b0, 1'b0);
    next_cycle();
    RST = 1'b0;
    model_clear();
`ifdef DCACHE_STATS_EN
    m_hits   = 32'h0;
    m_misses = 32'h0;
`endif
    do_read(32'h204, 1, 32'h77778888, 1'b0, 1'b0);
    do_read(32'h40, 1, 32'h99990000, 1'b0, 1'b0);

    // Three hits, then reset clears the counters.
    do_reset(1'b0);
    do_read(32'h40, 1, 32'h31415926, 1'b0, 1'b0);
    repeat (3) do_read(32'h40, 0, 32'h0, 1'b0, 1'b0);
`ifdef DCACHE_STATS_EN
    checkOutput("pin_hit_count", hit_count, 32'd3);
`endif
    do_reset(1'b0);
`ifdef DCACHE_STATS_EN
    checkOutput("pin_hit_count_rst", hit_count, 32'd0);
`endif

    // Halt flush, then reset: previously cached line must miss.
    do_read(32'h40, 1, 32'h27182818, 1'b0, 1'b0);
    do_halt();
    do_reset(1'b1);
    checkOutput("pin_flushed_0x40", {31'b0, model_hit(32'h40)}, 32'h0);
    do_read(32'h40, 2, 32'h16180339, 1'b0, 1'b0);

    chk_en = 1'b0;
    $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
